s2p_deframer: RTL and testbench
===============================

Name: s2p_deframer

Overview:
- Parametrised serial-to-parallel deframer for the Hamming-coded link; successor to the fixed 14-bit, "11"-header receiver.
- Hunts a configurable sync pattern in the serial bit stream, then captures a DATA_W-bit payload MSB-first, with an optional even-parity bit.
- Delivers each frame through a valid/ready output register to the Hamming decoder.
- Adds bit-strobe qualification, backpressure, overflow reporting and a frame counter.

Parameters:
- DATA_W, 14: payload width in bits (2..64).
- SYNC_LEN, 2: sync pattern length in bits (1..16).
- SYNC_PAT, 2'b11: sync pattern, SYNC_LEN bits wide; its MSB is received first.
- PARITY_EN, 0: 1 means one even-parity bit follows the payload.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- din_valid, in, 1: bit strobe; din is sampled only on cycles where this is 1.
- din, in, 1: serial data bit.
- dout, out, DATA_W: frame payload; the first received bit is dout[DATA_W-1].
- out_valid, out, 1: dout holds an undelivered frame.
- out_ready, in, 1: consumer accepts the frame.
- parity_err, out, 1: parity failed for the frame in dout; 0 when PARITY_EN=0.
- overflow, out, 1: sticky; a completed frame was dropped.
- ovf_clr, in, 1: synchronous clear of overflow.
- busy, out, 1: state is not HUNT.
- frame_cnt, out, 16: count of frames loaded into dout; wraps from 0xFFFF to 0.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-frame):
  - state = HUNT; sync shift register, payload shift register and bit counter cleared.
  - dout = 0, out_valid = 0, parity_err = 0, overflow = 0, busy = 0, frame_cnt = 0.
  - Any partial frame is discarded.
- "Accepted bit" means a rising edge with din_valid=1. Cycles with din_valid=0 change nothing except the output handshake and ovf_clr.
- State HUNT:
  - Each accepted bit shifts into the SYNC_LEN-bit window.
  - If {window[SYNC_LEN-2:0], din} == SYNC_PAT, go to RECV on that edge with bit count 0. When SYNC_LEN=1, compare din alone.
  - Window state is not required to match SYNC_PAT before SYNC_LEN bits have been received since the last reset or frame end; it holds zeros after clearing.
- State RECV:
  - Each accepted bit shifts left into the payload register (first bit ends at the MSB) and increments the count.
  - The edge accepting bit DATA_W-1 (count == DATA_W-1) ends the payload.
  - If PARITY_EN=1, go to PAR; otherwise complete the frame.
- State PAR: the next accepted bit is the parity bit. parity_err_next = (XOR of payload) XOR bit. Then complete the frame.
- Frame completion, on the same edge as the last accepted bit:
  - Return to HUNT and clear the sync window. Payload bits never contribute to the next sync match.
  - If out_valid=0, or out_ready=1 on that edge: load dout and parity_err, set out_valid=1, frame_cnt +1.
  - Otherwise: the frame is dropped, dout is unchanged and overflow is set.
- Latency: dout and out_valid become visible in the cycle after the edge that accepted the final bit.
- Output handshake:
  - Transfer occurs when out_valid=1 and out_ready=1.
  - With no new completion on that edge, out_valid goes to 0; dout holds its last value.
  - If a completion and a transfer coincide, the new frame loads and out_valid stays 1. Back-to-back frames lose no cycle.
  - dout and parity_err are stable while out_valid=1 and out_ready=0.
- overflow: set on a drop; cleared by ovf_clr. If a drop and ovf_clr occur on the same edge, set wins.
- busy = 1 in RECV and PAR.
- Width rules:
  - Bit counter width is clog2(DATA_W)+1.
  - frame_cnt is 16-bit modulo.
- No timeout: a stalled din_valid holds the state indefinitely.

Test Plan:
- Defaults; din_valid=1 each cycle; send 0,0,1,1 then payload 14'b10110011100101 -> out_valid rises one cycle after the last payload bit; dout=0x2CE5; frame_cnt=1; overflow=0.
- Defaults; din_valid toggled 1,0,1,0 across the same frame -> identical dout. Idle cycles ignored. out_valid rises one cycle after the strobe of the last bit.
- Defaults; out_ready=0; two complete frames A=0x1234 and B=0x0F0F -> dout=0x1234 held; overflow=1; frame_cnt=1. Pulse ovf_clr -> overflow=0. Assert out_ready -> out_valid drops.
- PARITY_EN=1, DATA_W=8, SYNC_LEN=3, SYNC_PAT=3'b101; send 101, payload 0xA5, parity bit 0 -> dout=0xA5, parity_err=0. Repeat with parity bit 1 -> parity_err=1.
- Defaults; rst_n pulsed low after 7 payload bits; then a fresh sync and payload 0x3FFF -> no frame from the aborted attempt; dout=0x3FFF; frame_cnt=1.
- Defaults; payload 14'b11111111111111 followed immediately by 1,1 and a second payload -> the second frame is captured only after the sync that follows completion. Coincident completion with out_ready=1 keeps out_valid=1 and frame_cnt=2.

Source files
------------

// File: rtl/s2p_deframer.sv
// Serial-to-parallel deframer: hunts a sync pattern, captures a DATA_W-bit
// MSB-first payload with optional even parity, and offers it on a valid/ready register.
module s2p_deframer #(
  parameter int                  DATA_W    = 14,
  parameter int                  SYNC_LEN  = 2,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT  = 2'b11,
  parameter bit                  PARITY_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {HUNT, RECV, PAR} state_t;

  state_t              state;
  state_t              state_next;
  logic [SYNC_LEN-1:0] sync_win;
  logic [SYNC_LEN-1:0] win_next;
  logic [DATA_W-1:0]   payload;
  logic [DATA_W-1:0]   pay_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic                sync_hit;
  logic                last_data;
  logic                complete;
  logic                load;
  logic                drop;
  logic [DATA_W-1:0]   frame_data;
  logic                frame_perr;

  // A one-bit pattern has no history, so the window degenerates to din alone.
  generate
    if (SYNC_LEN == 1) begin : g_win1
      assign win_next = din;
    end else begin : g_winn
      assign win_next = {sync_win[SYNC_LEN-2:0], din};
    end
  endgenerate

  assign pay_next   = {payload[DATA_W-2:0], din};
  assign sync_hit   = (win_next == SYNC_PAT);
  assign last_data  = (bit_cnt == CNT_W'(DATA_W - 1));
  assign frame_data = (state == PAR) ? payload : pay_next;
  assign frame_perr = (state == PAR) ? ((^payload) ^ din) : 1'b0;
  assign load       = complete && (!out_valid || out_ready);
  assign drop       = complete && out_valid && !out_ready;
  assign busy       = (state != HUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: if (sync_hit) state_next = RECV;
        RECV: begin
          if (last_data) begin
            if (PARITY_EN) begin
              state_next = PAR;
            end else begin
              state_next = HUNT;
              complete   = 1'b1;
            end
          end
        end
        PAR: begin
          state_next = HUNT;
          complete   = 1'b1;
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // The window is cleared on sync, so payload bits never feed the next hunt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_win   <= '0;
      payload    <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (sync_hit) begin
              sync_win <= '0;
              bit_cnt  <= '0;
            end else begin
              sync_win <= win_next;
            end
          end
          RECV: begin
            payload <= pay_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
          default: ;
        endcase
      end

      if (load) begin
        dout       <= frame_data;
        parity_err <= frame_perr;
        out_valid  <= 1'b1;
        frame_cnt  <= frame_cnt + 16'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_s2p_deframer.sv
// Scoreboarded bench for s2p_deframer: a default-parameter instance and a
// parity-enabled 8-bit instance with a 3-bit sync pattern.
module tb_s2p_deframer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        dv0 = 1'b0, din0 = 1'b0, rdy0 = 1'b0, clr0 = 1'b0;
  logic [13:0] dout0;
  logic        ov0, pe0, ovf0, busy0;
  logic [15:0] cnt0;

  logic        dv1 = 1'b0, din1 = 1'b0, rdy1 = 1'b0, clr1 = 1'b0;
  logic [7:0]  dout1;
  logic        ov1, pe1, ovf1, busy1;
  logic [15:0] cnt1;

  int checks = 0;
  int failures = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [15:0] last0 = 16'd0;
  logic [15:0] last1 = 16'd0;

  s2p_deframer dut0 (
    .clk(clk), .rst_n(rst_n), .din_valid(dv0), .din(din0), .dout(dout0),
    .out_valid(ov0), .out_ready(rdy0), .parity_err(pe0), .overflow(ovf0),
    .ovf_clr(clr0), .busy(busy0), .frame_cnt(cnt0)
  );

  s2p_deframer #(
    .DATA_W(8), .SYNC_LEN(3), .SYNC_PAT(3'b101), .PARITY_EN(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .din_valid(dv1), .din(din1), .dout(dout1),
    .out_valid(ov1), .out_ready(rdy1), .parity_err(pe1), .overflow(ovf1),
    .ovf_clr(clr1), .busy(busy1), .frame_cnt(cnt1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [63:0] bits, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      if (which == 0) begin din0 = bits[i]; dv0 = 1'b1; end
      else            begin din1 = bits[i]; dv1 = 1'b1; end
      if (gap && i > 0) begin
        @(negedge clk);
        dv0 = 1'b0;
        dv1 = 1'b0;
      end
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    dv0 = 1'b0;
    dv1 = 1'b0;
  endtask

  task automatic resetAll();
    @(negedge clk);
    rst_n = 1'b0;
    dv0 = 1'b0; din0 = 1'b0; rdy0 = 1'b0; clr0 = 1'b0;
    dv1 = 1'b0; din1 = 1'b0; rdy1 = 1'b0; clr1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Each frame_cnt step marks a newly loaded frame; compare it to the scoreboard head.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && cnt0 == 16'(last0 + 16'd1)) begin
      if (q0.size() == 0) checkOutput("dut0_unexpected_frame", 64'(dout0), 64'hDEAD);
      else begin
        e = q0.pop_front();
        checkOutput("dut0_frame", 64'(dout0), e);
      end
    end
    last0 = cnt0;
    if (rst_n && cnt1 == 16'(last1 + 16'd1)) begin
      if (q1.size() == 0) checkOutput("dut1_unexpected_frame", 64'({pe1, dout1}), 64'hDEAD);
      else begin
        e = q1.pop_front();
        checkOutput("dut1_frame", 64'({pe1, dout1}), e);
      end
    end
    last1 = cnt1;
  end

  initial begin
    logic [13:0] p2;

    // Reset state and a plain frame with a continuous strobe.
    resetAll();
    checkOutput("rst_dout", 64'(dout0), 64'h0);
    checkOutput("rst_valid", 64'(ov0), 64'h0);
    checkOutput("rst_perr", 64'(pe0), 64'h0);
    checkOutput("rst_ovf", 64'(ovf0), 64'h0);
    checkOutput("rst_busy", 64'(busy0), 64'h0);
    checkOutput("rst_cnt", 64'(cnt0), 64'h0);
    rdy0 = 1'b1;
    q0.push_back(64'h2CE5);
    applyStimulus(0, {4'b0011, 13'b1011001110010}, 17, 1'b0);
    checkOutput("t1_busy_mid", 64'(busy0), 64'h1);
    checkOutput("t1_valid_early", 64'(ov0), 64'h0);
    applyStimulus(0, 64'h1, 1, 1'b0);
    idleCycle();
    checkOutput("t1_valid", 64'(ov0), 64'h1);
    checkOutput("t1_cnt", 64'(cnt0), 64'h1);
    checkOutput("t1_ovf", 64'(ovf0), 64'h0);
    checkOutput("t1_busy_end", 64'(busy0), 64'h0);
    idleCycle();
    checkOutput("t1_valid_drop", 64'(ov0), 64'h0);

    // Same frame with idle cycles between strobes.
    resetAll();
    rdy0 = 1'b1;
    q0.push_back(64'h2CE5);
    applyStimulus(0, {4'b0011, 14'b10110011100101}, 18, 1'b1);
    idleCycle();
    checkOutput("t2_valid", 64'(ov0), 64'h1);
    checkOutput("t2_cnt", 64'(cnt0), 64'h1);

    // Backpressure: second frame dropped, overflow sticky until cleared.
    resetAll();
    q0.push_back(64'h1234);
    applyStimulus(0, {2'b11, 14'h1234}, 16, 1'b0);
    applyStimulus(0, {2'b11, 14'h0F0F}, 16, 1'b0);
    idleCycle();
    checkOutput("t3_dout_held", 64'(dout0), 64'h1234);
    checkOutput("t3_ovf", 64'(ovf0), 64'h1);
    checkOutput("t3_cnt", 64'(cnt0), 64'h1);
    checkOutput("t3_valid", 64'(ov0), 64'h1);
    @(negedge clk); clr0 = 1'b1;
    @(negedge clk); clr0 = 1'b0;
    checkOutput("t3_ovf_clr", 64'(ovf0), 64'h0);
    checkOutput("t3_valid_stall", 64'(ov0), 64'h1);
    rdy0 = 1'b1;
    @(negedge clk);
    checkOutput("t3_valid_drop", 64'(ov0), 64'h0);
    checkOutput("t3_dout_keep", 64'(dout0), 64'h1234);

    // Parity instance: good then bad parity.
    resetAll();
    rdy1 = 1'b1;
    q1.push_back({55'h0, 1'b0, 8'hA5});
    applyStimulus(1, {3'b101, 8'hA5, 1'b0}, 12, 1'b0);
    idleCycle();
    checkOutput("t4_valid", 64'(ov1), 64'h1);
    checkOutput("t4_perr0", 64'(pe1), 64'h0);
    q1.push_back({55'h0, 1'b1, 8'hA5});
    applyStimulus(1, {3'b101, 8'hA5, 1'b1}, 12, 1'b0);
    idleCycle();
    checkOutput("t4_perr1", 64'(pe1), 64'h1);
    checkOutput("t4_cnt", 64'(cnt1), 64'h2);

    // Reset in mid-frame discards the partial payload.
    resetAll();
    rdy0 = 1'b1;
    applyStimulus(0, {4'b0011, 7'b1010101}, 11, 1'b0);
    idleCycle();
    checkOutput("t5_busy_mid", 64'(busy0), 64'h1);
    rst_n = 1'b0;
    #2;
    checkOutput("t5_busy_rst", 64'(busy0), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    q0.push_back(64'h3FFF);
    applyStimulus(0, {4'b0011, 14'h3FFF}, 18, 1'b0);
    idleCycle();
    checkOutput("t5_valid", 64'(ov0), 64'h1);
    checkOutput("t5_cnt", 64'(cnt0), 64'h1);

    // Back-to-back: sync after an all-ones payload, completion coincides with transfer.
    resetAll();
    p2 = 14'h2AAA;
    q0.push_back(64'h3FFF);
    q0.push_back(64'h2AAA);
    applyStimulus(0, {2'b11, 14'h3FFF}, 16, 1'b0);
    applyStimulus(0, {2'b11, p2[13:1]}, 15, 1'b0);
    @(negedge clk);
    din0 = p2[0];
    dv0 = 1'b1;
    rdy0 = 1'b1;
    idleCycle();
    checkOutput("t6_valid", 64'(ov0), 64'h1);
    checkOutput("t6_cnt", 64'(cnt0), 64'h2);
    checkOutput("t6_ovf", 64'(ovf0), 64'h0);
    idleCycle();
    checkOutput("t6_valid_drop", 64'(ov0), 64'h0);

    idleCycle();
    checkOutput("q0_empty", 64'(q0.size()), 64'h0);
    checkOutput("q1_empty", 64'(q1.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
